gcd_core: RTL and testbench
===========================

GCD_CORE -- requirements
Module: gcd_core

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Parameter: CNT_W, default 8, iteration-counter width in bits (used only with GCD_ITER_CNT_EN).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when ready=1.
REQ-006 a_in  input  WIDTH  operand A, unsigned; captured with an accepted start.
REQ-007 b_in  input  WIDTH  operand B, unsigned; captured with an accepted start.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 busy  output  1  high in CALC only.
REQ-010 finish  output  1  one-cycle pulse, high in DONE only.
REQ-011 result  output  WIDTH  GCD of the last completed job; registered.
REQ-012 zero_err  output  1  last completed job had at least one zero operand; registered.
REQ-013 iter_cnt  output  CNT_W  subtraction count of the last job; present only with GCD_ITER_CNT_EN.

Function
REQ-014 The block SHALL implement the FSM with states IDLE, CALC and DONE, and SHALL use one subtract-and-compare step per cycle on internal registers A and B.
REQ-015 IDLE: when start=1, the block SHALL load A=a_in and B=b_in.
- If A or B is 0, the next state SHALL be DONE.
- Otherwise, the next state SHALL be CALC.
REQ-016 IDLE: when start=0, the block SHALL remain in IDLE.
REQ-017 Each CALC cycle SHALL apply exactly one of the following:
- A==B: go to DONE.
- A>B: A<=A-B.
- B>A: B<=B-A.
REQ-018 Subtraction SHALL be WIDTH-bit unsigned; underflow SHALL be impossible because the larger operand is always the minuend.
REQ-019 On the transition into DONE, result SHALL be loaded as follows:
- From CALC: A.
- From IDLE with zero operand(s): A|B, giving gcd(x,0)=x and gcd(0,0)=0.
REQ-020 On the transition into DONE, zero_err SHALL be loaded with (a_in==0)||(b_in==0) for the job.
REQ-021 DONE SHALL last exactly one cycle with finish=1, then return unconditionally to IDLE.
REQ-022 result and zero_err SHALL hold their value until the next entry into DONE or reset.
REQ-023 Latency: with edge 1 defined as the edge that samples start and N as the number of subtractions, finish SHALL be high in the cycle following edge N+2.
- Zero-operand jobs SHALL have finish high in the cycle following edge 1.
REQ-024 start asserted while busy=1 or finish=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 a_in and b_in SHALL be don't-care except in the cycle where start is accepted.
REQ-026 ready, busy and finish SHALL be mutually exclusive and SHALL be decoded from the state register only.

Reset
REQ-027 When reset=1 at a rising edge, regardless of state, the block SHALL enter IDLE and clear A, B, result and zero_err to 0 (and iter_cnt to 0 when present).
REQ-028 Reset SHALL take priority over start in the same cycle.
REQ-029 A job interrupted by reset SHALL be abandoned without asserting finish.
REQ-030 After reset the outputs SHALL be ready=1, busy=0 and finish=0.

Configuration
REQ-031 Macro GCD_ITER_CNT_EN defined: the iter_cnt port and an internal counter SHALL exist.
- The counter SHALL clear on an accepted start.
- It SHALL increment once per CALC subtraction and saturate at all-ones.
- It SHALL be copied to iter_cnt on entry to DONE and held like result.
REQ-032 Macro GCD_ITER_CNT_EN undefined: the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 WIDTH=8, a_in=12, b_in=18 -> result=6, N=2, finish high after edge 4, zero_err=0, iter_cnt=2.
REQ-034 a_in=7, b_in=7 -> N=0, finish high after edge 2, result=7.
REQ-035 a_in=0, b_in=9 -> finish high after edge 1, result=9, zero_err=1; a_in=0, b_in=0 -> result=0, zero_err=1.
REQ-036 WIDTH=8, a_in=255, b_in=1 -> result=1, N=254, iter_cnt=254; start pulses during CALC -> ignored, exactly one finish pulse.
REQ-037 Reset asserted on the 3rd CALC cycle of a 12/18 job -> ready=1 next cycle, no finish, result=0; a new start 40/16 -> result=8.
REQ-038 Back-to-back jobs with start held high -> new job accepted in the IDLE cycle after DONE; result holds the previous value until the new DONE.

Source files
------------

// File: rtl/gcd_core.sv
`default_nettype none
// ============================================================================
// Module      : gcd_core
// Description : Iterative subtractive GCD engine. Each job computes the GCD of
//               two unsigned WIDTH-bit operands. The engine performs one
//               subtract-and-compare step per clock cycle.
//
//               Ports:
//                 clk       - single clock, rising edge
//                 reset     - synchronous, active-high
//                 start     - job request, sampled only while ready=1
//                 a_in/b_in - operands, captured with an accepted start
//                 ready     - high in IDLE
//                 busy      - high in CALC
//                 finish    - one-cycle pulse in DONE
//                 result    - GCD of the last completed job (registered)
//                 zero_err  - last completed job had a zero operand
//                 iter_cnt  - subtraction count of the last job
//                             (only with GCD_ITER_CNT_EN)
//
//               Optional feature macro: GCD_ITER_CNT_EN adds the iteration
//               counter and the iter_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_core #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] result,
    output logic             zero_err
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [CNT_W-1:0] iter_cnt
`endif
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    // Reject unsupported configurations at elaboration time.
    if (WIDTH < 2 || WIDTH > 32 || CNT_W < 1) begin : g_param_check
        $error("gcd_core: WIDTH must be 2..32 and CNT_W must be >= 1");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             w_in_zero;
    logic             w_accept;
    logic             w_equal;

    assign w_in_zero = (a_in == '0) || (b_in == '0);
    assign w_accept  = (r_state == c_idle) && start;
    assign w_equal   = (r_a == r_b);

    // Status outputs come straight from the state register.
    assign ready  = (r_state == c_idle);
    assign busy   = (r_state == c_calc);
    assign finish = (r_state == c_done);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    // A zero operand needs no iteration at all.
                    w_next_state = w_in_zero ? c_done : c_calc;
                end
            end
            c_calc: begin
                if (w_equal) begin
                    w_next_state = c_done;
                end
            end
            c_done: begin
                w_next_state = c_idle;
            end
            default: begin
                w_next_state = c_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand registers and registered results
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            result   <= '0;
            zero_err <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_a <= a_in;
                        r_b <= b_in;
                        if (w_in_zero) begin
                            // OR of the operands yields gcd(x,0)=x and gcd(0,0)=0.
                            result   <= a_in | b_in;
                            zero_err <= 1'b1;
                        end
                    end
                end
                c_calc: begin
                    if (w_equal) begin
                        result   <= r_a;
                        zero_err <= 1'b0;
                    end else if (r_a > r_b) begin
                        // Larger operand is always the minuend: no underflow.
                        r_a <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GCD_ITER_CNT_EN
    // ------------------------------------------------------------------
    // Iteration counter: counts subtractions, saturates at all-ones
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            iter_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (w_in_zero) begin
                // The job completes without any subtraction.
                iter_cnt <= '0;
            end
        end else if (busy) begin
            if (w_equal) begin
                iter_cnt <= r_cnt;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_core
// Description : Self-checking bench for gcd_core. Expected results come from
//               a vector table; a scoreboard queue holds the expected result,
//               flag, subtraction count and completion edge for each accepted
//               job and is checked on every finish pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_core;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          ready;
    logic          busy;
    logic          finish;
    logic [W-1:0]  result;
    logic          zero_err;
`ifdef GCD_ITER_CNT_EN
    logic [CW-1:0] iter_cnt;
`endif

    gcd_core #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .ready    (ready),
        .busy     (busy),
        .finish   (finish),
        .result   (result),
        .zero_err (zero_err)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       zero;
        int         n;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        int         n;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk    = 0;
    int   n_err    = 0;
    int   edge_cnt = 0;
    int   fin_cnt  = 0;
    bit   prev_fin = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Monitor: pops the scoreboard on every finish pulse.
    always @(negedge clk) begin
        if (prev_fin) check("done_one_cycle", {ready, busy, finish}, 3'b100);
        prev_fin = finish;
        if (finish) begin
            fin_cnt++;
            check("finish_exclusive", {ready, busy}, 2'b00);
            if (sb.size() == 0) begin
                check("unexpected_finish", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("zero_err", zero_err, mon_e.zero);
                check("finish_edge", edge_cnt, mon_e.due);
`ifdef GCD_ITER_CNT_EN
                check("iter_cnt", iter_cnt, mon_e.n);
`endif
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called while ready=1 and start is being raised for the next edge.
    task automatic push_exp(input vec_t v);
        exp_t e;
        e.res  = v.res;
        e.zero = v.zero;
        e.n    = v.n;
        e.due  = edge_cnt + 1 + (v.zero ? 0 : v.n + 1);
        sb.push_back(e);
    endtask

    task automatic wait_ready;
        int k = 0;
        while (!ready && k < 1000) begin
            tick();
            k++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_drain;
        int k = 0;
        while ((sb.size() != 0 || !ready) && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic run_job(input vec_t v);
        wait_ready();
        start = 1'b1;
        a_in  = v.a;
        b_in  = v.b;
        push_exp(v);
        tick();
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        wait_drain();
        tick();
        check("result_hold", result, v.res);
    endtask

    vec_t vt[13];
    vec_t bb[3];
    vec_t vj;

    initial begin
        int f0;
        int idx;
        bit hold_checked;

        vt[0]  = '{8'd12,  8'd18,  8'd6,   1'b0, 2};
        vt[1]  = '{8'd7,   8'd7,   8'd7,   1'b0, 0};
        vt[2]  = '{8'd0,   8'd9,   8'd9,   1'b1, 0};
        vt[3]  = '{8'd0,   8'd0,   8'd0,   1'b1, 0};
        vt[4]  = '{8'd9,   8'd0,   8'd9,   1'b1, 0};
        vt[5]  = '{8'd40,  8'd16,  8'd8,   1'b0, 3};
        vt[6]  = '{8'd1,   8'd1,   8'd1,   1'b0, 0};
        vt[7]  = '{8'd100, 8'd75,  8'd25,  1'b0, 3};
        vt[8]  = '{8'd17,  8'd5,   8'd1,   1'b0, 6};
        vt[9]  = '{8'd128, 8'd64,  8'd64,  1'b0, 1};
        vt[10] = '{8'd255, 8'd255, 8'd255, 1'b0, 0};
        vt[11] = '{8'd1,   8'd255, 8'd1,   1'b0, 254};
        vt[12] = '{8'd18,  8'd12,  8'd6,   1'b0, 2};

        // Reset state
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        check("rst_result", result, 0);
        check("rst_zero_err", zero_err, 0);
`ifdef GCD_ITER_CNT_EN
        check("rst_iter_cnt", iter_cnt, 0);
`endif

        // Table-driven jobs
        for (int i = 0; i < 13; i++) run_job(vt[i]);

        // 255/1 with start pulses during CALC: only one finish expected
        vj = '{8'd255, 8'd1, 8'd1, 1'b0, 254};
        wait_ready();
        f0    = fin_cnt;
        start = 1'b1;
        a_in  = vj.a;
        b_in  = vj.b;
        push_exp(vj);
        tick();
        for (int k = 0; k < 1000 && sb.size() != 0; k++) begin
            start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (4) tick();
        check("single_finish", fin_cnt - f0, 1);
        check("idle_after_ignored", ready, 1);

        // Reset on the 3rd CALC cycle of a 12/18 job, with start also high
        wait_ready();
        f0    = fin_cnt;
        start = 1'b1;
        a_in  = 8'd12;
        b_in  = 8'd18;
        vj    = '{8'd12, 8'd18, 8'd6, 1'b0, 2};
        push_exp(vj);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("third_calc_busy", busy, 1);
        reset = 1'b1;
        start = 1'b1;
        a_in  = 8'd3;
        b_in  = 8'd3;
        sb.delete();
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_finish", finish, 0);
        check("abort_result", result, 0);
        check("abort_zero_err", zero_err, 0);
        repeat (4) tick();
        check("abort_no_finish", fin_cnt - f0, 0);
        vj = '{8'd40, 8'd16, 8'd8, 1'b0, 3};
        run_job(vj);

        // Back-to-back jobs with start held high
        bb[0] = '{8'd12, 8'd18, 8'd6, 1'b0, 2};
        bb[1] = '{8'd7,  8'd7,  8'd7, 1'b0, 0};
        bb[2] = '{8'd0,  8'd9,  8'd9, 1'b1, 0};
        idx = 0;
        hold_checked = 1'b0;
        wait_ready();
        for (int k = 0; k < 500; k++) begin
            if (idx == 3 && sb.size() == 0 && ready) break;
            if (ready && idx < 3) begin
                start = 1'b1;
                a_in  = bb[idx].a;
                b_in  = bb[idx].b;
                push_exp(bb[idx]);
                idx++;
            end else if (ready) begin
                start = 1'b0;
            end else begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
                if (busy && idx == 2 && !hold_checked) begin
                    check("b2b_hold_prev", result, 6);
                    hold_checked = 1'b1;
                end
            end
            tick();
        end
        start = 1'b0;
        check("b2b_all_accepted", idx, 3);
        check("b2b_drained", sb.size(), 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
